ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Shares the single dual-bank SRAM access controller (re/we strobes, 17-bit address with bit 16 selecting the bank, 16-bit write/read data) between two requesters.
- Requester 0 is the RAM test sequencer. Requester 1 is the UART loader.
- Sequences each access as setup -> strobe -> hold, so the shared controller always sees stable address/data around a clean single strobe.
- Returns read data and a one-cycle ack to the winning requester.

Parameters:
- STROBE_CYC, 2, number of cycles re/we is held high (1..15).
- ADDR_W, 17, access address width; MSB is the bank select.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 access request (level; held until ack0)
- wr0  in  1  requester 0: 1=write, 0=read
- addr0  in  ADDR_W  requester 0 address
- wdata0  in  16  requester 0 write data
- ack0  out  1  one-cycle pulse: requester 0 access complete
- req1, wr1, addr1, wdata1, ack1  same as requester 0, for requester 1
- rdata  out  16  read data of last completed read; valid with the ack pulse, held afterwards
- ram_re  out  1  read strobe to RAM controller
- ram_we  out  1  write strobe to RAM controller
- ram_addr  out  ADDR_W  address to RAM controller
- ram_wdata  out  16  write data to RAM controller
- ram_rdata  in  16  read data from RAM controller
- busy  out  1  high in any state other than IDLE
- owner  out  1  index of the requester granted the current or most recent access

Behaviour:
- Reset (async, rst=1): state=IDLE; ram_re=ram_we=0; ram_addr=0; ram_wdata=0; rdata=0; ack0=ack1=0; busy=0; owner=0; rr_last=1, so requester 0 wins the first tie.
- States:
  - IDLE: sample req0/req1. Go to SETUP if either is high; otherwise stay.
  - SETUP (1 cycle): latch the winner's addr/wdata/wr into ram_addr/ram_wdata/op; set owner. Strobes stay 0.
  - STROBE (STROBE_CYC cycles): ram_re=~op or ram_we=op, as registered outputs. A 4-bit counter loads STROBE_CYC-1 and decrements; exit at 0.
  - HOLD (1 cycle): both strobes 0; address/data unchanged. On a read, capture rdata<=ram_rdata at the end of this cycle. ram_rdata is sampled on the HOLD-cycle edge.
  - DONE (1 cycle): ackN=1 for the owner only; go to IDLE.
- Latency: request seen in IDLE -> ack asserted 3+STROBE_CYC cycles later (5 at default).
- ram_re and ram_we are never high together. Neither is high outside STROBE.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester not equal to rr_last wins.
  - rr_last updates to the winner in SETUP.
- A requester must hold req and its inputs until ack. The arbiter uses only the copies latched in SETUP, so changes after SETUP are ignored.
- The requester drops req in the cycle after ack. If req is still high in IDLE after DONE, it is treated as a new access.
- Only IDLE looks at requests, so back-to-back accesses have a 1-cycle IDLE gap.
- Reset mid-access: strobes drop immediately and no ack is issued. The requester must re-request.
- A write leaves rdata unchanged.
- Addresses pass through unmodified; bank select is ram_addr[ADDR_W-1].

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both request; rr_last is not used. Requester 1 can be starved.
- Undefined: round-robin as above.

Test Plan:
- Single write: req0=1, wr0=1, addr0=0x00005, wdata0=0x1234 -> ram_we high exactly 2 cycles with ram_addr=0x00005 and ram_wdata=0x1234; ram_re never high; ack0 pulses 5 cycles after the request.
- Read back: req0 read of addr 0x00005, model returns 0x1234 -> rdata=0x1234 at the ack0 cycle; ram_re high for 2 cycles; ram_we stays 0.
- Contention: req0 and req1 high together, each held for 3 accesses -> grant order 0,1,0,1,0,1; owner matches each ack.
- Fixed priority (ARB_FIXED_PRIO_EN): both requests held continuously -> only ack0 pulses over 10 accesses.
- Reset mid-strobe: assert rst while ram_we=1 -> ram_we=0 the same cycle; no ack; busy=0; the next access completes normally.
- Bank select: req1 write to 0x10003 -> ram_addr[16]=1 throughout strobe; STROBE_CYC=4 build shows a 4-cycle strobe and 7-cycle latency.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-requester arbiter sequencing setup/strobe/hold SRAM accesses; `ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins)
module ram_access_arbiter #(
  parameter int STROBE_CYC = 2,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [15:0]       wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata1,
  output logic              ack1,
  output logic [15:0]       rdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic              busy,
  output logic              owner
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic op_q, op_d, owner_q, owner_d, re_q, re_d, we_q, we_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic take, gnt;
`ifdef ARB_FIXED_PRIO_EN
  // requester 0 always wins a tie, so requester 1 wins only when alone
  assign gnt = ~req0;
`else
  logic rr_q, rr_d;
  // on a tie the requester that did not win last time is granted
  assign gnt = (req0 & req1) ? ~rr_q : req1;
  assign rr_d = take ? gnt : rr_q;
  // round-robin history; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_q <= 1'b1;
    else rr_q <= rr_d;
`endif
  assign take = (state_q == IDLE) & (req0 | req1);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next-state: only IDLE looks at requests; STROBE exits when the counter reaches 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = take ? SETUP : IDLE;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = (cnt_q == 4'd0) ? HOLD : STROBE;
      HOLD:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // output/datapath next values: winner copies latched on entry to SETUP, strobes and acks registered
  always_comb begin
    addr_d  = take ? (gnt ? addr1 : addr0) : addr_q;
    wdata_d = take ? (gnt ? wdata1 : wdata0) : wdata_q;
    op_d    = take ? (gnt ? wr1 : wr0) : op_q;
    owner_d = take ? gnt : owner_q;
    cnt_d   = (state_q == SETUP) ? 4'(STROBE_CYC - 1) :
              (state_q == STROBE && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    re_d    = (state_d == STROBE) & ~op_q;
    we_d    = (state_d == STROBE) & op_q;
    rdata_d = (state_q == HOLD && !op_q) ? ram_rdata : rdata_q;
    ack0_d  = (state_d == DONE) & ~owner_q;
    ack1_d  = (state_d == DONE) & owner_q;
  end
  // datapath and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      owner_q <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      re_q    <= re_d;
      we_q    <= we_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_re    = re_q;
  assign ram_we    = we_q;
  assign rdata     = rdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign owner     = owner_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed self-checking bench with a small SRAM model
module tb_ram_access_arbiter;
  logic clk = 0, rst = 1;
  logic req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
  logic [16:0] addr0 = 0, addr1 = 0;
  logic [15:0] wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, ram_re, ram_we, busy, owner;
  logic [16:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata, rdata;
  logic [15:0] mem [0:31];
  int cmp = 0, err = 0;

  ram_access_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[{ram_addr[16], ram_addr[3:0]}];
  always @(posedge clk) if (ram_we) mem[{ram_addr[16], ram_addr[3:0]}] <= ram_wdata;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input bit r, input bit w, input logic [16:0] a, input logic [15:0] d,
                            output int lat, output int we_n, output int re_n,
                            output bit addr_ok, output bit bad);
    if (r) begin req1 = 1; wr1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1; wr0 = w; addr0 = a; wdata0 = d; end
    lat = -1; we_n = 0; re_n = 0; addr_ok = 1; bad = 0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      step();
      if (ram_we) we_n++;
      if (ram_re) re_n++;
      if ((ram_we | ram_re) && (ram_addr !== a || (w && ram_wdata !== d))) addr_ok = 0;
      if (ram_we && ram_re) bad = 1;
      if (r ? ack0 : ack1) bad = 1;
      if (r ? ack1 : ack0) lat = c;
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    #1;
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
    cmp++; if ({ram_re, ram_we} !== 2'b00) begin err++; $display("FAIL reset_strobes: got %b want 00", {ram_re, ram_we}); end
    cmp++; if (ram_addr !== 17'h0 || ram_wdata !== 16'h0) begin err++; $display("FAIL reset_addr_data: got %h/%h want 0/0", ram_addr, ram_wdata); end
    cmp++; if (rdata !== 16'h0) begin err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    cmp++; if ({ack0, ack1, owner} !== 3'b000) begin err++; $display("FAIL reset_ack_owner: got %b want 000", {ack0, ack1, owner}); end
    step();
    rst = 0;
    step();
  endtask

  task automatic test_single_write;
    int lat, we_n, re_n; bit ok, bad;
    run_access(0, 1, 17'h00005, 16'h1234, lat, we_n, re_n, ok, bad);
    cmp++; if (lat !== 5) begin err++; $display("FAIL write_latency: got %0d want 5", lat); end
    cmp++; if (we_n !== 2) begin err++; $display("FAIL write_we_cycles: got %0d want 2", we_n); end
    cmp++; if (re_n !== 0) begin err++; $display("FAIL write_re_cycles: got %0d want 0", re_n); end
    cmp++; if (ok !== 1'b1 || bad !== 1'b0) begin err++; $display("FAIL write_addr_data: ok=%b bad=%b want 1/0", ok, bad); end
    cmp++; if (owner !== 1'b0) begin err++; $display("FAIL write_owner: got %b want 0", owner); end
    step();
    cmp++; if ({ack0, busy} !== 2'b00) begin err++; $display("FAIL write_ack_pulse: ack0/busy got %b want 00", {ack0, busy}); end
    cmp++; if (mem[5] !== 16'h1234) begin err++; $display("FAIL write_mem: got %h want 1234", mem[5]); end
  endtask

  task automatic test_read_back;
    int lat, we_n, re_n; bit ok, bad;
    run_access(0, 0, 17'h00005, 16'h0, lat, we_n, re_n, ok, bad);
    cmp++; if (lat !== 5) begin err++; $display("FAIL read_latency: got %0d want 5", lat); end
    cmp++; if (rdata !== 16'h1234) begin err++; $display("FAIL read_rdata: got %h want 1234", rdata); end
    cmp++; if (re_n !== 2 || we_n !== 0) begin err++; $display("FAIL read_strobes: re=%0d we=%0d want 2/0", re_n, we_n); end
    cmp++; if (ok !== 1'b1 || bad !== 1'b0) begin err++; $display("FAIL read_addr: ok=%b bad=%b want 1/0", ok, bad); end
    step();
    run_access(0, 1, 17'h00009, 16'hBEEF, lat, we_n, re_n, ok, bad);
    cmp++; if (rdata !== 16'h1234) begin err++; $display("FAIL write_keeps_rdata: got %h want 1234", rdata); end
    step();
  endtask

  task automatic test_bank_select;
    int lat, we_n, re_n; bit ok, bad;
    run_access(1, 1, 17'h10003, 16'hA5A5, lat, we_n, re_n, ok, bad);
    cmp++; if (lat !== 5 || we_n !== 2) begin err++; $display("FAIL bank_write: lat=%0d we=%0d want 5/2", lat, we_n); end
    cmp++; if (ok !== 1'b1 || bad !== 1'b0) begin err++; $display("FAIL bank_addr: ok=%b bad=%b want 1/0", ok, bad); end
    cmp++; if (owner !== 1'b1 || ram_addr[16] !== 1'b1) begin err++; $display("FAIL bank_owner_bit16: got %b%b want 11", owner, ram_addr[16]); end
    step();
    run_access(1, 0, 17'h10003, 16'h0, lat, we_n, re_n, ok, bad);
    cmp++; if (rdata !== 16'hA5A5) begin err++; $display("FAIL bank1_read: got %h want a5a5", rdata); end
    step();
    run_access(0, 0, 17'h00003, 16'h0, lat, we_n, re_n, ok, bad);
    cmp++; if (rdata !== 16'h0000) begin err++; $display("FAIL bank0_read: got %h want 0000", rdata); end
    step();
  endtask

  task automatic test_back_to_back;
    bit [5:0] expv;
    int got, cyc;
`ifdef ARB_FIXED_PRIO_EN
    expv = 6'b000000;
`else
    expv = 6'b101010;
`endif
    rst = 1; step(); rst = 0; step();
    req0 = 1; wr0 = 0; addr0 = 17'h00005;
    req1 = 1; wr1 = 0; addr1 = 17'h10003;
    for (int i = 0; i < 6; i++) begin
      got = -1; cyc = -1;
      for (int c = 1; c <= 20 && got < 0; c++) begin
        step();
        if (ack0 && ack1) got = 2;
        else if (ack0) got = 0;
        else if (ack1) got = 1;
        if (got >= 0) cyc = c;
      end
      if (i == 5) begin req0 = 0; req1 = 0; end
      cmp++; if (got !== int'(expv[i])) begin err++; $display("FAIL grant_%0d: got %0d want %0d", i, got, expv[i]); end
      cmp++; if (owner !== expv[i]) begin err++; $display("FAIL owner_%0d: got %b want %b", i, owner, expv[i]); end
      cmp++; if (cyc !== (i == 0 ? 5 : 6)) begin err++; $display("FAIL gap_%0d: got %0d want %0d", i, cyc, i == 0 ? 5 : 6); end
    end
    step();
    step();
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL contention_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat, we_n, re_n, seen; bit ok, bad;
    req0 = 1; wr0 = 1; addr0 = 17'h00007; wdata0 = 16'h7777;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (ram_we) seen = 1;
    end
    cmp++; if (seen !== 1) begin err++; $display("FAIL mid_strobe_seen: got %0d want 1", seen); end
    rst = 1;
    #1;
    cmp++; if ({ram_we, busy, ack0} !== 3'b000) begin err++; $display("FAIL mid_reset_drop: we/busy/ack0 got %b want 000", {ram_we, busy, ack0}); end
    step();
    cmp++; if ({ram_we, ack0, ack1} !== 3'b000) begin err++; $display("FAIL mid_reset_noack: got %b want 000", {ram_we, ack0, ack1}); end
    cmp++; if (mem[7] !== 16'h0000) begin err++; $display("FAIL mid_reset_nowrite: got %h want 0000", mem[7]); end
    rst = 0;
    run_access(0, 1, 17'h00007, 16'h7777, lat, we_n, re_n, ok, bad);
    cmp++; if (lat !== 5 || we_n !== 2) begin err++; $display("FAIL after_reset_access: lat=%0d we=%0d want 5/2", lat, we_n); end
    step();
    cmp++; if (mem[7] !== 16'h7777) begin err++; $display("FAIL after_reset_mem: got %h want 7777", mem[7]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    test_reset();
    test_single_write();
    test_read_back();
    test_bank_select();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
